// File: rtl/div_pkg.sv
// ---------------------------------------------------------------------------
// div_pkg
// Shared definitions for the sequential restoring divider:
//   state_t    - FSM state encoding (IDLE / RUN / DONE)
//   cnt_width  - width of an iteration counter that must hold the value n
// ---------------------------------------------------------------------------
package div_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Bits needed to represent 0..n inclusive.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/restore_step.sv
// ---------------------------------------------------------------------------
// restore_step
// One combinational iteration of unsigned restoring division.
// Ports:
//   rem_w     in  DIVISOR_W+1  partial remainder before this step
//   msb_in    in  1            dividend bit shifted into the remainder
//   divisor   in  DIVISOR_W    divisor
//   rem_next  out DIVISOR_W+1  partial remainder after this step
//   q_bit     out 1            quotient bit produced by this step
// ---------------------------------------------------------------------------
module restore_step #(
    parameter int DIVISOR_W = 3
) (
    input  logic [DIVISOR_W:0]   rem_w,
    input  logic                 msb_in,
    input  logic [DIVISOR_W-1:0] divisor,
    output logic [DIVISOR_W:0]   rem_next,
    output logic                 q_bit
);

    localparam int RW = DIVISOR_W + 1;

    // One extra bit so the shifted value cannot overflow before the trial.
    logic [DIVISOR_W+1:0] shifted;
    logic [DIVISOR_W+1:0] div_ext;

    always_comb begin
        shifted  = {rem_w, msb_in};
        div_ext  = {2'b00, divisor};
        q_bit    = 1'b0;
        rem_next = RW'(shifted);
        if (shifted >= div_ext) begin
            q_bit    = 1'b1;
            rem_next = RW'(shifted - div_ext);
        end
    end

endmodule

// File: rtl/seq_restoring_divider.sv
// ---------------------------------------------------------------------------
// seq_restoring_divider
// Multi-cycle unsigned restoring divider, one quotient bit per clock, behind
// a start/ready/done handshake. Results satisfy q*d + r == dividend.
// Ports:
//   clk          in   1           clock, rising edge
//   rst          in   1           asynchronous active-high reset
//   start        in   1           request, accepted only while ready==1
//   dividend     in   DIVIDEND_W  sampled on the accepting edge
//   divisor      in   DIVISOR_W   sampled on the accepting edge
//   ready        out  1           high in IDLE
//   done         out  1           one-cycle pulse (state DONE)
//   quotient     out  DIVIDEND_W  last result, held until next DONE
//   remainder    out  DIVISOR_W   last result, held until next DONE
//   div_by_zero  out  1           last result was a divide by zero
// ---------------------------------------------------------------------------
module seq_restoring_divider
    import div_pkg::*;
#(
    parameter int DIVIDEND_W = 6,
    parameter int DIVISOR_W  = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  ready,
    output logic                  done,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_by_zero
);

    localparam int CNT_W = cnt_width(DIVIDEND_W);

    state_t                state;
    logic [DIVISOR_W:0]    rem_w;
    logic [DIVIDEND_W-1:0] quo_w;
    logic [DIVISOR_W-1:0]  div_w;
    logic [CNT_W-1:0]      cnt;

    logic [DIVISOR_W:0]    rem_next;
    logic                  q_bit;

    restore_step #(
        .DIVISOR_W (DIVISOR_W)
    ) u_step (
        .rem_w    (rem_w),
        .msb_in   (quo_w[DIVIDEND_W-1]),
        .divisor  (div_w),
        .rem_next (rem_next),
        .q_bit    (q_bit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            ready       <= 1'b1;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            rem_w       <= '0;
            quo_w       <= '0;
            div_w       <= '0;
            cnt         <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        rem_w <= '0;
                        quo_w <= dividend;
                        div_w <= divisor;
                        cnt   <= CNT_W'(DIVIDEND_W);
                        ready <= 1'b0;
                        if (divisor == '0) begin
                            // Zero divisor resolves immediately without iterating.
                            quotient    <= '1;
                            remainder   <= dividend[DIVISOR_W-1:0];
                            div_by_zero <= 1'b1;
                            done        <= 1'b1;
                            state       <= ST_DONE;
                        end else begin
                            state <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    // Dividend bits shift out of quo_w's MSB while quotient bits fill its LSB.
                    rem_w <= rem_next;
                    quo_w <= {quo_w[DIVIDEND_W-2:0], q_bit};
                    cnt   <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        quotient    <= {quo_w[DIVIDEND_W-2:0], q_bit};
                        remainder   <= rem_next[DIVISOR_W-1:0];
                        div_by_zero <= 1'b0;
                        done        <= 1'b1;
                        state       <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    ready <= 1'b1;
                    state <= ST_IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    ready <= 1'b1;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_restoring_divider.sv
module tb_seq_restoring_divider;

    logic       clk;
    logic       rst;
    logic       start;
    logic [5:0] dividend;
    logic [2:0] divisor;
    logic       ready;
    logic       done;
    logic [5:0] quotient;
    logic [2:0] remainder;
    logic       div_by_zero;

    int checks = 0;
    int errors = 0;

    seq_restoring_divider #(
        .DIVIDEND_W (6),
        .DIVISOR_W  (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .ready       (ready),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Launch one operation and return the number of edges after the
    // accepting edge at which done was first seen (20 = timed out).
    task automatic run_op(input logic [5:0] a, input logic [2:0] b, output int lat);
        int n;
        n = 0;
        while (!ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        while (!done && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
        #2;
        checks++;
        if (ready !== 1'b1 || done !== 1'b0 || quotient !== 6'd0 ||
            remainder !== 3'd0 || div_by_zero !== 1'b0) begin
            errors++;
            $display("FAIL reset: ready=%b done=%b q=%0d r=%0d dbz=%b, expected 1 0 0 0 0",
                     ready, done, quotient, remainder, div_by_zero);
        end
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        logic [5:0] va [4];
        logic [2:0] vb [4];
        logic [5:0] eq [4];
        logic [2:0] er [4];
        int lat;
        va = '{6'd42, 6'd63, 6'd0, 6'd49};
        vb = '{3'd5,  3'd7,  3'd3, 3'd1};
        eq = '{6'd8,  6'd9,  6'd0, 6'd49};
        er = '{3'd2,  3'd0,  3'd0, 3'd0};
        for (int i = 0; i < 4; i++) begin
            run_op(va[i], vb[i], lat);
            checks++;
            if (lat !== 6) begin
                errors++;
                $display("FAIL basic_latency %0d/%0d: got %0d edges, expected 6", va[i], vb[i], lat);
            end
            checks++;
            if (quotient !== eq[i] || remainder !== er[i] || div_by_zero !== 1'b0) begin
                errors++;
                $display("FAIL basic_result %0d/%0d: got q=%0d r=%0d dbz=%b, expected q=%0d r=%0d dbz=0",
                         va[i], vb[i], quotient, remainder, div_by_zero, eq[i], er[i]);
            end
            @(posedge clk); #1;
            checks++;
            if (done !== 1'b0 || ready !== 1'b1) begin
                errors++;
                $display("FAIL basic_done_pulse %0d/%0d: got done=%b ready=%b, expected 0 1",
                         va[i], vb[i], done, ready);
            end
        end
    endtask

    task automatic test_div_zero();
        int lat;
        run_op(6'd45, 3'd0, lat);
        checks++;
        if (lat !== 0) begin
            errors++;
            $display("FAIL dbz_latency: got %0d edges after accept, expected 0", lat);
        end
        checks++;
        if (quotient !== 6'h3F || remainder !== 3'd5 || div_by_zero !== 1'b1) begin
            errors++;
            $display("FAIL dbz_result: got q=%h r=%0d dbz=%b, expected q=3f r=5 dbz=1",
                     quotient, remainder, div_by_zero);
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0 || ready !== 1'b1 || div_by_zero !== 1'b1) begin
            errors++;
            $display("FAIL dbz_hold: got done=%b ready=%b dbz=%b, expected 0 1 1", done, ready, div_by_zero);
        end
    endtask

    task automatic test_ignore_start();
        int ndone;
        int first;
        int rdy_err;
        ndone = 0; first = -1; rdy_err = 0;
        dividend = 6'd42; divisor = 3'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            if (k == 2) begin
                dividend = 6'd10; divisor = 3'd2; start = 1'b1;
            end
            @(posedge clk); #1;
            if (k == 2) start = 1'b0;
            if (done) begin
                ndone++;
                if (first < 0) begin
                    first = k;
                    checks++;
                    if (quotient !== 6'd8 || remainder !== 3'd2) begin
                        errors++;
                        $display("FAIL ignore_result: got q=%0d r=%0d, expected q=8 r=2", quotient, remainder);
                    end
                end
            end
            if (k <= 6 && ready !== 1'b0) rdy_err++;
            if (k >= 7 && ready !== 1'b1) rdy_err++;
        end
        checks++;
        if (ndone !== 1 || first !== 6) begin
            errors++;
            $display("FAIL ignore_done: got %0d dones first at edge %0d, expected 1 at edge 6", ndone, first);
        end
        checks++;
        if (rdy_err !== 0) begin
            errors++;
            $display("FAIL ignore_ready: got %0d cycles with wrong ready, expected 0", rdy_err);
        end
    endtask

    task automatic test_reset_midrun();
        int ndone;
        int lat;
        ndone = 0;
        dividend = 6'd42; divisor = 3'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); @(posedge clk); @(posedge clk); #2;
        rst = 1'b1;
        #1;
        checks++;
        if (ready !== 1'b1 || done !== 1'b0 || quotient !== 6'd0 ||
            remainder !== 3'd0 || div_by_zero !== 1'b0) begin
            errors++;
            $display("FAIL midrun_reset: ready=%b done=%b q=%0d r=%0d dbz=%b, expected 1 0 0 0 0",
                     ready, done, quotient, remainder, div_by_zero);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        checks++;
        if (ndone !== 0) begin
            errors++;
            $display("FAIL midrun_nodone: got %0d dones, expected 0", ndone);
        end
        run_op(6'd20, 3'd3, lat);
        checks++;
        if (lat !== 6 || quotient !== 6'd6 || remainder !== 3'd2 || div_by_zero !== 1'b0) begin
            errors++;
            $display("FAIL midrun_next: got lat=%0d q=%0d r=%0d dbz=%b, expected lat=6 q=6 r=2 dbz=0",
                     lat, quotient, remainder, div_by_zero);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_exhaustive();
        int ndone;
        int bad;
        int n;
        logic [5:0] a;
        logic [2:0] b;
        ndone = 0; bad = 0;
        start = 1'b1;
        for (int i = 0; i < 512; i++) begin
            a = 6'(i / 8);
            b = 3'(i % 8);
            dividend = a;
            divisor  = b;
            n = 0;
            do begin
                @(posedge clk); #1;
                n++;
            end while (!done && n < 20);
            if (i == 511) start = 1'b0;
            if (done) begin
                ndone++;
                if (b == 3'd0) begin
                    if (quotient !== 6'h3F || remainder !== a[2:0] || div_by_zero !== 1'b1) begin
                        bad++;
                        if (bad <= 5)
                            $display("FAIL exh_zero %0d/0: got q=%h r=%0d dbz=%b, expected q=3f r=%0d dbz=1",
                                     a, quotient, remainder, div_by_zero, a[2:0]);
                    end
                end else begin
                    if (int'(quotient) * int'(b) + int'(remainder) != int'(a) ||
                        remainder >= b || div_by_zero !== 1'b0) begin
                        bad++;
                        if (bad <= 5)
                            $display("FAIL exh_div %0d/%0d: got q=%0d r=%0d dbz=%b, expected q=%0d r=%0d dbz=0",
                                     a, b, quotient, remainder, div_by_zero, a / b, a % b);
                    end
                end
            end
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL exhaustive: got %0d bad results, expected 0", bad);
        end
        checks++;
        if (ndone !== 512) begin
            errors++;
            $display("FAIL exh_count: got %0d dones, expected 512", ndone);
        end
        @(posedge clk); @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_div_zero();
        test_ignore_start();
        test_reset_midrun();
        test_exhaustive();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
